// File: rtl/adder32_serial.sv
// adder32_serial: multi-cycle adder, one SLICE-bit slice per clock, with carry-out and signed overflow.
module adder32_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflow
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] op_a, op_b, part, part_nx;
  logic [CW-1:0] cnt;
  logic carry, accept, last, msb_cin;
  logic [SLICE-1:0] sa, sb;
  logic [SLICE:0] sum;
  assign accept = start && state != RUN;
  assign last   = cnt == CW'(N - 1);
  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign sa     = op_a[cnt*SLICE +: SLICE];
  assign sb     = op_b[cnt*SLICE +: SLICE];
  assign sum    = {1'b0, sa} + {1'b0, sb} + {{SLICE{1'b0}}, carry};
  // carry into the top bit of a slice is recovered from the sum bit and its operands
  assign msb_cin = sum[SLICE-1] ^ sa[SLICE-1] ^ sb[SLICE-1];
  always_comb begin
    part_nx = part;
    part_nx[cnt*SLICE +: SLICE] = sum[SLICE-1:0];
    state_nx = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_a     <= '0;
      op_b     <= '0;
      part     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      op_a  <= A;
      op_b  <= B;
      carry <= carryIn;
      part  <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      part  <= part_nx;
      carry <= sum[SLICE];
      cnt   <= last ? '0 : cnt + CW'(1);
      if (last) begin
        result   <= part_nx;
        carryOut <= sum[SLICE];
        overflow <= msb_cin ^ sum[SLICE];
      end
    end
  end
endmodule

// File: tb/tb_adder32_serial.sv
// tb_adder32_serial: directed and randomised checks of the slice-serial adder.
module tb_adder32_serial;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic carryIn = 1'b0;
  logic busy, done, carryOut, overflow;
  logic [31:0] result;
  int vec = 0, errs = 0;

  adder32_serial dut (
    .clock(clock), .reset(reset), .start(start), .A(A), .B(B), .carryIn(carryIn),
    .busy(busy), .done(done), .result(result), .carryOut(carryOut), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Launches one operation and waits (bounded) until done is seen; stops on the done negedge.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                    output int busy_n, output bit got_done);
    @(negedge clock);
    A = a; B = b; carryIn = ci; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    busy_n = 0;
    got_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin got_done = 1; break; end
      if (busy) busy_n++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    int n; bit d;
    vec++;
    if ({busy, done, carryOut, overflow, result} !== 36'h0) begin
      errs++; $display("FAIL reset_initial got %h exp 0", {busy, done, carryOut, overflow, result});
    end
    @(negedge clock); reset = 1'b1;
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, n, d);
    vec++;
    if ({d, carryOut, overflow, result} !== {1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF}) begin
      errs++; $display("FAIL reset_preop got %h exp %h", {d, carryOut, overflow, result}, {1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF});
    end
    @(negedge clock);
    A = 32'h1234; B = 32'h1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    vec++;
    if ({busy, done, carryOut, overflow, result} !== 36'h0) begin
      errs++; $display("FAIL reset_midrun got %h exp 0", {busy, done, carryOut, overflow, result});
    end
    @(negedge clock); reset = 1'b1;
    repeat (5) @(negedge clock);
    vec++;
    if ({busy, done, result} !== 34'h0) begin
      errs++; $display("FAIL reset_stay_idle got %h exp 0", {busy, done, result});
    end
    op(32'h1, 32'h2, 1'b0, n, d);
    #1 reset = 1'b0;
    #1;
    vec++;
    if ({d, done} !== 2'b10) begin
      errs++; $display("FAIL reset_in_done got %b exp 10", {d, done});
    end
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_overflow;
    int n; bit d;
    op(32'h7FFF_FFFF, 32'h1, 1'b0, n, d);
    vec++;
    if ({d, busy, carryOut, overflow, result} !== {1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000}) begin
      errs++; $display("FAIL signed_ovf got %h exp %h", {d, busy, carryOut, overflow, result}, {1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000});
    end
    vec++;
    if (n !== 4) begin errs++; $display("FAIL signed_ovf_busy got %0d exp 4", n); end
    @(negedge clock);
    vec++;
    if (done !== 1'b0) begin errs++; $display("FAIL done_one_cycle got %b exp 0", done); end
  endtask

  task automatic test_wrap;
    int n; bit d;
    op(32'hFFFF_FFFF, 32'h1, 1'b0, n, d);
    vec++;
    if ({d, carryOut, overflow, result} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      errs++; $display("FAIL unsigned_wrap got %h exp %h", {d, carryOut, overflow, result}, {1'b1, 1'b1, 1'b0, 32'h0});
    end
  endtask

  task automatic test_cross_slice;
    int n; bit d;
    op(32'h00FF_FFFF, 32'h0, 1'b1, n, d);
    vec++;
    if ({d, carryOut, overflow, result} !== {1'b1, 1'b0, 1'b0, 32'h0100_0000}) begin
      errs++; $display("FAIL cross_carry got %h exp %h", {d, carryOut, overflow, result}, {1'b1, 1'b0, 1'b0, 32'h0100_0000});
    end
    op(32'h8000_0000, 32'h8000_0000, 1'b0, n, d);
    vec++;
    if ({d, carryOut, overflow, result} !== {1'b1, 1'b1, 1'b1, 32'h0}) begin
      errs++; $display("FAIL neg_ovf got %h exp %h", {d, carryOut, overflow, result}, {1'b1, 1'b1, 1'b1, 32'h0});
    end
  endtask

  task automatic test_ignore_start;
    int n = 0;
    @(negedge clock);
    A = 32'h1234_5678; B = 32'h1111_1111; carryIn = 1'b0; start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D; carryIn = 1'b1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clock);
    vec++;
    if ({done, result} !== {1'b1, 32'h2345_6789}) begin
      errs++; $display("FAIL start_in_run got %h exp %h", {done, result}, {1'b1, 32'h2345_6789});
    end
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      if (busy || done) n++;
      @(negedge clock);
    end
    vec++;
    if (n !== 0) begin errs++; $display("FAIL start_not_queued got %0d exp 0", n); end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    @(negedge clock);
    A = 32'h10; B = 32'h20; carryIn = 1'b0; start = 1'b1;
    @(negedge clock);
    A = 32'd5; B = 32'd7;
    for (int i = 0; i < 20 && !done; i++) @(negedge clock);
    vec++;
    if ({done, result} !== {1'b1, 32'h30}) begin
      errs++; $display("FAIL b2b_first got %h exp %h", {done, result}, {1'b1, 32'h30});
    end
    @(negedge clock); start = 1'b0;
    vec++;
    if ({busy, done, result} !== {1'b1, 1'b0, 32'h30}) begin
      errs++; $display("FAIL b2b_hold got %h exp %h", {busy, done, result}, {1'b1, 1'b0, 32'h30});
    end
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) n++;
      if (busy && done) begin errs++; $display("FAIL busy_and_done got 1 exp 0"); end
      @(negedge clock);
    end
    vec++;
    if ({done, n, result} !== {1'b1, 32'd4, 32'd12}) begin
      errs++; $display("FAIL b2b_second got done=%b busy=%0d res=%h exp 1 4 0000000c", done, n, result);
    end
  endtask

  task automatic test_random;
    int n; bit d;
    logic [31:0] a, b;
    logic ci;
    logic [32:0] s;
    for (int k = 0; k < 1000; k++) begin
      a = $urandom; b = $urandom; ci = 1'($urandom_range(1));
      if (k % 4 == 0) begin a[31] = 1'b0; b[31] = 1'b0; end
      repeat ($urandom_range(3)) @(negedge clock);
      op(a, b, ci, n, d);
      s = {1'b0, a} + {1'b0, b} + {32'b0, ci};
      vec++;
      if ({d, carryOut, result, overflow} !== {1'b1, s, (a[31] == b[31]) && (s[31] != a[31])}) begin
        errs++;
        $display("FAIL random a=%h b=%h ci=%b got d=%b %b_%h ov=%b exp %h ov=%b", a, b, ci, d,
                 carryOut, result, overflow, s, (a[31] == b[31]) && (s[31] != a[31]));
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_overflow();
    test_wrap();
    test_cross_slice();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
